// File: rtl/wb_stage_buf.sv
// Write-back stage: decodes the MEM-stage bus and queues register writes in a
// 2-entry FIFO that drains to the regfile. The optional retire counter is built when WB_RETIRE_CNT_EN is defined.
module wb_stage_buf #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned OP_W   = 4
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic [OP_W+REG_AW+2*DATA_W:0]   membus,
  output logic                            mem_ready,
  output logic [REG_AW+DATA_W:0]          wbbus,
  input  logic                            wb_ack,
  output logic [REG_AW-1:0]               wb_dest,
  output logic [(2**REG_AW)-1:0]          pend_mask
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]                     retire_cnt
`endif
);

  localparam int unsigned MB_W = 1 + OP_W + REG_AW + 2 * DATA_W;
  localparam int unsigned WB_W = 1 + REG_AW + DATA_W;
  localparam int unsigned NREG = 2 ** REG_AW;

  // MEM-stage bus fields
  logic              mb_valid;
  logic [OP_W-1:0]   mb_op;
  logic [REG_AW-1:0] mb_dest;
  logic [DATA_W-1:0] mb_ex;
  logic [DATA_W-1:0] mb_mem;

  assign mb_valid = membus[MB_W-1];
  assign mb_op    = membus[MB_W-2 -: OP_W];
  assign mb_dest  = membus[2*DATA_W +: REG_AW];
  assign mb_ex    = membus[DATA_W +: DATA_W];
  assign mb_mem   = membus[0 +: DATA_W];

  logic              dec_writes;
  logic [DATA_W-1:0] dec_value;

  assign dec_writes = (!mb_op[3] && (|mb_op[2:0]))
                    || (mb_op[3] && !mb_op[2] && !mb_op[1])
                    || (!mb_op[2] && mb_op[1] && !mb_op[0]);
  assign dec_value  = (mb_op[3] && mb_op[1]) ? mb_mem : mb_ex;

  logic [REG_AW-1:0] ent_dest     [2];
  logic [DATA_W-1:0] ent_val      [2];
  logic [1:0]        ent_vld;
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;

  logic [REG_AW-1:0] ent_dest_nxt [2];
  logic [DATA_W-1:0] ent_val_nxt  [2];
  logic [1:0]        ent_vld_nxt;
  logic              rd_ptr_nxt, wr_ptr_nxt;
  logic [1:0]        count_nxt;
  logic              accept, push, pop;
  logic              mem_ready_nxt;
  logic [WB_W-1:0]   wbbus_nxt;
  logic [REG_AW-1:0] wb_dest_nxt;
  logic [NREG-1:0]   pend_nxt;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]       retire_nxt;
`endif

  // Next FIFO state, then outputs derived from it so they are registered with the FIFO
  always_comb begin
    ent_dest_nxt = ent_dest;
    ent_val_nxt  = ent_val;
    ent_vld_nxt  = ent_vld;
    rd_ptr_nxt   = rd_ptr;
    wr_ptr_nxt   = wr_ptr;
    wbbus_nxt    = '0;
    wb_dest_nxt  = '0;
    pend_nxt     = '0;

    accept = mb_valid && (count != 2'd2);
    push   = accept && dec_writes;
    pop    = (count != 2'd0) && wb_ack;

    if (pop) begin
      ent_vld_nxt[rd_ptr] = 1'b0;
      rd_ptr_nxt          = ~rd_ptr;
    end
    if (push) begin
      ent_vld_nxt[wr_ptr]  = 1'b1;
      ent_dest_nxt[wr_ptr] = mb_dest;
      ent_val_nxt[wr_ptr]  = dec_value;
      wr_ptr_nxt           = ~wr_ptr;
    end
    count_nxt     = count + 2'(push) - 2'(pop);
    mem_ready_nxt = (count_nxt != 2'd2);

    if (count_nxt != 2'd0) begin
      wbbus_nxt   = {1'b1, ent_dest_nxt[rd_ptr_nxt], ent_val_nxt[rd_ptr_nxt]};
      wb_dest_nxt = ent_dest_nxt[rd_ptr_nxt];
    end
    if (ent_vld_nxt[0]) pend_nxt[ent_dest_nxt[0]] = 1'b1;
    if (ent_vld_nxt[1]) pend_nxt[ent_dest_nxt[1]] = 1'b1;

`ifdef WB_RETIRE_CNT_EN
    retire_nxt = retire_cnt + 32'(2'(accept && !dec_writes) + 2'(pop));
`endif
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ent_dest[0] <= '0;
      ent_dest[1] <= '0;
      ent_val[0]  <= '0;
      ent_val[1]  <= '0;
      ent_vld     <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      mem_ready   <= 1'b1;
      wbbus       <= '0;
      wb_dest     <= '0;
      pend_mask   <= '0;
`ifdef WB_RETIRE_CNT_EN
      retire_cnt  <= '0;
`endif
    end else begin
      ent_dest    <= ent_dest_nxt;
      ent_val     <= ent_val_nxt;
      ent_vld     <= ent_vld_nxt;
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr      <= wr_ptr_nxt;
      count       <= count_nxt;
      mem_ready   <= mem_ready_nxt;
      wbbus       <= wbbus_nxt;
      wb_dest     <= wb_dest_nxt;
      pend_mask   <= pend_nxt;
`ifdef WB_RETIRE_CNT_EN
      retire_cnt  <= retire_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_wb_stage_buf.sv
// Bench for wb_stage_buf: directed scenarios plus random traffic against a
// queue-based reference model of the write-back buffer.
module tb_wb_stage_buf;

  logic        clock = 1'b0;
  logic        resetn;
  logic [39:0] membus;
  logic        mem_ready;
  logic [19:0] wbbus;
  logic        wb_ack;
  logic [2:0]  wb_dest;
  logic [7:0]  pend_mask;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  wb_stage_buf dut (
    .clock     (clock),
    .resetn    (resetn),
    .membus    (membus),
    .mem_ready (mem_ready),
    .wbbus     (wbbus),
    .wb_ack    (wb_ack),
    .wb_dest   (wb_dest),
    .pend_mask (pend_mask)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt(retire_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  dest;
    logic [15:0] val;
  } ent_t;

  ent_t        q[$];
  logic [31:0] model_retire;
  int          checks   = 0;
  int          failures = 0;

  // Ops 1..10 write a register; ops 10, 11, 14, 15 take the load result
  function automatic logic op_writes(input logic [3:0] op);
    return op inside {[4'd1:4'd10]};
  endfunction

  function automatic logic op_from_mem(input logic [3:0] op);
    return op inside {4'd10, 4'd11, 4'd14, 4'd15};
  endfunction

  function automatic logic [19:0] model_wbbus();
    if (q.size() == 0) return 20'h0;
    return {1'b1, q[0]};
  endfunction

  function automatic logic [2:0] model_dest();
    if (q.size() == 0) return 3'd0;
    return q[0].dest;
  endfunction

  function automatic logic [7:0] model_mask();
    logic [7:0] m = 8'h0;
    foreach (q[i]) m[q[i].dest] = 1'b1;
    return m;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle
  task automatic tick(input logic v, input logic [3:0] op, input logic [2:0] d,
                      input logic [15:0] ex, input logic [15:0] mr,
                      input logic ack, input logic rst_n);
    logic acc, pop;
    resetn = rst_n;
    membus = {v, op, d, ex, mr};
    wb_ack = ack;
    @(posedge clock);
    if (!rst_n) begin
      q.delete();
      model_retire = 32'd0;
    end else begin
      acc = v && (q.size() < 2);
      pop = (q.size() > 0) && ack;
      if (pop) begin
        void'(q.pop_front());
        model_retire = model_retire + 32'd1;
      end
      if (acc) begin
        if (op_writes(op)) q.push_back({d, op_from_mem(op) ? mr : ex});
        else model_retire = model_retire + 32'd1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 4'b0001, 3'd3, 16'h5555, 16'h6666, 1'b0, 1'b0);
    tick(1'b1, 4'b0001, 3'd3, 16'h5555, 16'h6666, 1'b0, 1'b0);
    checks++;
    if (wbbus !== 20'h0) begin failures++; $display("FAIL reset_wbbus got %h exp 0", wbbus); end
    checks++;
    if (wb_dest !== 3'd0) begin failures++; $display("FAIL reset_wb_dest got %0d exp 0", wb_dest); end
    checks++;
    if (pend_mask !== 8'h0) begin failures++; $display("FAIL reset_pend got %h exp 00", pend_mask); end
    checks++;
    if (mem_ready !== 1'b1) begin failures++; $display("FAIL reset_mem_ready got %b exp 1", mem_ready); end
`ifdef WB_RETIRE_CNT_EN
    checks++;
    if (retire_cnt !== 32'd0) begin failures++; $display("FAIL reset_retire got %0d exp 0", retire_cnt); end
`endif
  endtask

  task automatic test_basic();
    tick(1'b1, 4'b0001, 3'd5, 16'h1234, 16'($urandom), 1'b1, 1'b1);
    checks++;
    if (wbbus !== {1'b1, 3'd5, 16'h1234}) begin failures++; $display("FAIL basic_wbbus got %h exp %h", wbbus, {1'b1, 3'd5, 16'h1234}); end
    checks++;
    if (pend_mask !== 8'h20) begin failures++; $display("FAIL basic_pend got %h exp 20", pend_mask); end
    checks++;
    if (wb_dest !== 3'd5) begin failures++; $display("FAIL basic_wb_dest got %0d exp 5", wb_dest); end
    tick(1'b0, 4'b0000, 3'd0, 16'h0, 16'h0, 1'b1, 1'b1);
    checks++;
    if (wbbus !== 20'h0) begin failures++; $display("FAIL basic_drain got %h exp 0", wbbus); end
  endtask

  task automatic test_decode();
    tick(1'b1, 4'b1010, 3'd2, 16'($urandom), 16'hBEEF, 1'b0, 1'b1);
    checks++;
    if (wbbus !== {1'b1, 3'd2, 16'hBEEF}) begin failures++; $display("FAIL load_wbbus got %h exp %h", wbbus, {1'b1, 3'd2, 16'hBEEF}); end
    tick(1'b1, 4'b1100, 3'd6, 16'h7777, 16'h8888, 1'b1, 1'b1);
    checks++;
    if (wbbus !== 20'h0) begin failures++; $display("FAIL nowrite_wbbus got %h exp 0", wbbus); end
    checks++;
    if (pend_mask !== 8'h0) begin failures++; $display("FAIL nowrite_pend got %h exp 00", pend_mask); end
`ifdef WB_RETIRE_CNT_EN
    checks++;
    if (retire_cnt !== model_retire) begin failures++; $display("FAIL decode_retire got %0d exp %0d", retire_cnt, model_retire); end
`endif
  endtask

  task automatic test_full();
    tick(1'b1, 4'b0001, 3'd1, 16'h0011, 16'h0, 1'b0, 1'b1);
    tick(1'b1, 4'b0001, 3'd3, 16'h0033, 16'h0, 1'b0, 1'b1);
    checks++;
    if (mem_ready !== 1'b0) begin failures++; $display("FAIL full_mem_ready got %b exp 0", mem_ready); end
    checks++;
    if (pend_mask !== 8'h0A) begin failures++; $display("FAIL full_pend got %h exp 0a", pend_mask); end
    tick(1'b1, 4'b0001, 3'd6, 16'h0066, 16'h0, 1'b0, 1'b1);
    checks++;
    if (wbbus !== {1'b1, 3'd1, 16'h0011}) begin failures++; $display("FAIL stall_head got %h exp %h", wbbus, {1'b1, 3'd1, 16'h0011}); end
    tick(1'b1, 4'b0001, 3'd6, 16'h0066, 16'h0, 1'b1, 1'b1);
    checks++;
    if (wbbus !== {1'b1, 3'd3, 16'h0033}) begin failures++; $display("FAIL pop_head got %h exp %h", wbbus, {1'b1, 3'd3, 16'h0033}); end
    checks++;
    if (pend_mask !== 8'h08) begin failures++; $display("FAIL pop_pend got %h exp 08", pend_mask); end
    checks++;
    if (mem_ready !== 1'b1) begin failures++; $display("FAIL pop_mem_ready got %b exp 1", mem_ready); end
    tick(1'b1, 4'b0001, 3'd6, 16'h0066, 16'h0, 1'b0, 1'b1);
    checks++;
    if (pend_mask !== 8'h48) begin failures++; $display("FAIL refill_pend got %h exp 48", pend_mask); end
    tick(1'b0, 4'b0000, 3'd0, 16'h0, 16'h0, 1'b1, 1'b1);
    tick(1'b0, 4'b0000, 3'd0, 16'h0, 16'h0, 1'b1, 1'b1);
    checks++;
    if (wbbus !== 20'h0) begin failures++; $display("FAIL full_drain got %h exp 0", wbbus); end
`ifdef WB_RETIRE_CNT_EN
    checks++;
    if (retire_cnt !== model_retire) begin failures++; $display("FAIL full_retire got %0d exp %0d", retire_cnt, model_retire); end
`endif
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 4'b0010, 3'd4, 16'hAAAA, 16'h0, 1'b0, 1'b1);
    checks++;
    if (pend_mask !== 8'h10) begin failures++; $display("FAIL b2b_first_pend got %h exp 10", pend_mask); end
    tick(1'b1, 4'b0010, 3'd4, 16'hBBBB, 16'h0, 1'b1, 1'b1);
    checks++;
    if (wbbus !== {1'b1, 3'd4, 16'hBBBB}) begin failures++; $display("FAIL b2b_head got %h exp %h", wbbus, {1'b1, 3'd4, 16'hBBBB}); end
    checks++;
    if (pend_mask !== 8'h10) begin failures++; $display("FAIL b2b_pend got %h exp 10", pend_mask); end
    checks++;
    if (mem_ready !== 1'b1) begin failures++; $display("FAIL b2b_mem_ready got %b exp 1", mem_ready); end
    tick(1'b0, 4'b0000, 3'd0, 16'h0, 16'h0, 1'b1, 1'b1);
    checks++;
    if (pend_mask !== 8'h0) begin failures++; $display("FAIL b2b_drain_pend got %h exp 00", pend_mask); end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 4'b0001, 3'd2, 16'h2222, 16'h0, 1'b0, 1'b1);
    tick(1'b1, 4'b1100, 3'd0, 16'h0, 16'h0, 1'b0, 1'b1);
    tick(1'b1, 4'b0001, 3'd7, 16'h7777, 16'h0, 1'b0, 1'b1);
    tick(1'b1, 4'b0001, 3'd5, 16'h5555, 16'h0, 1'b1, 1'b0);
    checks++;
    if (wbbus !== 20'h0) begin failures++; $display("FAIL rmid_wbbus got %h exp 0", wbbus); end
    checks++;
    if (pend_mask !== 8'h0) begin failures++; $display("FAIL rmid_pend got %h exp 00", pend_mask); end
    checks++;
    if (mem_ready !== 1'b1) begin failures++; $display("FAIL rmid_mem_ready got %b exp 1", mem_ready); end
`ifdef WB_RETIRE_CNT_EN
    checks++;
    if (retire_cnt !== 32'd0) begin failures++; $display("FAIL rmid_retire got %0d exp 0", retire_cnt); end
`endif
    tick(1'b0, 4'b0000, 3'd0, 16'h0, 16'h0, 1'b1, 1'b1);
    checks++;
    if (wbbus !== 20'h0) begin failures++; $display("FAIL rmid_stale got %h exp 0", wbbus); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      tick(($urandom_range(99) < 70), 4'($urandom), 3'($urandom), 16'($urandom),
           16'($urandom), ($urandom_range(99) < 60), ($urandom_range(99) >= 2));
      checks++;
      if (wbbus !== model_wbbus()) begin failures++; $display("FAIL rnd_wbbus cyc %0d got %h exp %h", n, wbbus, model_wbbus()); end
      checks++;
      if (wb_dest !== model_dest()) begin failures++; $display("FAIL rnd_wb_dest cyc %0d got %0d exp %0d", n, wb_dest, model_dest()); end
      checks++;
      if (pend_mask !== model_mask()) begin failures++; $display("FAIL rnd_pend cyc %0d got %h exp %h", n, pend_mask, model_mask()); end
      checks++;
      if (mem_ready !== (q.size() != 2)) begin failures++; $display("FAIL rnd_mem_ready cyc %0d got %b exp %b", n, mem_ready, (q.size() != 2)); end
`ifdef WB_RETIRE_CNT_EN
      checks++;
      if (retire_cnt !== model_retire) begin failures++; $display("FAIL rnd_retire cyc %0d got %0d exp %0d", n, retire_cnt, model_retire); end
`endif
    end
  endtask

  initial begin
    resetn       = 1'b0;
    membus       = '0;
    wb_ack       = 1'b0;
    model_retire = 32'd0;
    test_reset();
    test_basic();
    test_decode();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
